// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer that shares one 8:1 single-bit select path between eight requesters.
// Grant latency is 1 cycle. A grant holds while ready is low, and after HOLD_MAX accepted beats the grant rotates.
module mux8_rr_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] d,
    input  logic       ready,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       y,
    output logic       y_valid,
    output logic       busy
);

    localparam int CW = (HOLD_MAX + 1 > 2) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_MAX - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_n;
    logic [2:0]    ptr, ptr_n, sel_n;
    logic [7:0]    gnt_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          y_n, y_valid_n;
    logic          beat, rel, found;
    logic [2:0]    scan_ptr, win;

    // First requester at or after p, wrapping modulo 8.
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic       f;
        logic [2:0] w;
        logic [2:0] idx;
        f = 1'b0;
        w = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = p + 3'(k);
            if (!f && r[idx]) begin
                f = 1'b1;
                w = idx;
            end
        end
        return {f, w};
    endfunction

    always_comb begin
        beat     = (state == GRANT) && ready && req[sel];
        rel      = (state == GRANT) && (!req[sel] || (beat && cnt == LAST));
        // On release the scan starts just past the outgoing grantee.
        scan_ptr = rel ? sel + 3'd1 : ptr;
        {found, win} = pick(req, scan_ptr);

        state_n   = state;
        ptr_n     = ptr;
        sel_n     = sel;
        gnt_n     = gnt;
        cnt_n     = cnt;
        y_n       = y;
        y_valid_n = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    gnt_n   = 8'(1) << win;
                    sel_n   = win;
                    cnt_n   = '0;
                end else begin
                    gnt_n = '0;
                end
            end
            GRANT: begin
                if (beat) begin
                    y_n       = d[sel];
                    y_valid_n = 1'b1;
                    cnt_n     = cnt + CW'(1);
                end
                if (rel) begin
                    ptr_n = sel + 3'd1;
                    cnt_n = '0;
                    if (found) begin
                        gnt_n = 8'(1) << win;
                        sel_n = win;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            sel     <= '0;
            gnt     <= '0;
            cnt     <= '0;
            y       <= 1'b0;
            y_valid <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            sel     <= sel_n;
            gnt     <= gnt_n;
            cnt     <= cnt_n;
            y       <= y_n;
            y_valid <= y_valid_n;
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed vector bench for mux8_rr_arbiter with HOLD_MAX=4 and HOLD_MAX=1 instances sharing stimulus.
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req, d;
    logic       ready;

    logic [7:0] gnt4, gnt1;
    logic [2:0] sel4, sel1;
    logic       y4, y1, yv4, yv1, busy4, busy1;

    int total = 0;
    int bad   = 0;

    mux8_rr_arbiter #(.HOLD_MAX(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .d(d), .ready(ready),
        .gnt(gnt4), .sel(sel4), .y(y4), .y_valid(yv4), .busy(busy4)
    );

    mux8_rr_arbiter #(.HOLD_MAX(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .d(d), .ready(ready),
        .gnt(gnt1), .sel(sel1), .y(y1), .y_valid(yv1), .busy(busy1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [7:0] req;
        logic [7:0] d;
        logic       ready;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       y;
        logic       yv;
        logic       busy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [7:0] rq, input logic [7:0] dd,
                                input logic rdy, input logic [7:0] g, input logic [2:0] s,
                                input logic yy, input logic v, input logic b);
        vec_t t;
        t.rst = r; t.req = rq; t.d = dd; t.ready = rdy;
        t.gnt = g; t.sel = s; t.y = yy; t.yv = v; t.busy = b;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got {gnt,sel,y,yv,busy}=%h want=%h", name, act, exp);
        end
    endtask

    vec_t tbl[30];

    initial begin
        logic [7:0] dv;
        int k;

        tbl[0]  = mk(1, 8'hFF, 8'h00, 1, 8'h00, 0, 0, 0, 0);
        tbl[1]  = mk(1, 8'hFF, 8'h00, 1, 8'h00, 0, 0, 0, 0);
        tbl[2]  = mk(0, 8'hFF, 8'h00, 1, 8'h01, 0, 0, 0, 1);
        tbl[3]  = mk(1, 8'h08, 8'h08, 1, 8'h00, 0, 0, 0, 0);
        tbl[4]  = mk(0, 8'h08, 8'h08, 1, 8'h08, 3, 0, 0, 1);
        tbl[5]  = mk(0, 8'h08, 8'h08, 1, 8'h08, 3, 1, 1, 1);
        tbl[6]  = mk(0, 8'h08, 8'h08, 1, 8'h08, 3, 1, 1, 1);
        tbl[7]  = mk(0, 8'h08, 8'h08, 1, 8'h08, 3, 1, 1, 1);
        tbl[8]  = mk(0, 8'h08, 8'h08, 1, 8'h08, 3, 1, 1, 1);
        tbl[9]  = mk(0, 8'h08, 8'h08, 1, 8'h08, 3, 1, 1, 1);
        tbl[10] = mk(1, 8'h44, 8'h04, 1, 8'h00, 0, 0, 0, 0);
        tbl[11] = mk(0, 8'h44, 8'h04, 0, 8'h04, 2, 0, 0, 1);
        tbl[12] = mk(0, 8'h44, 8'h04, 1, 8'h04, 2, 1, 1, 1);
        tbl[13] = mk(0, 8'h44, 8'h04, 1, 8'h04, 2, 1, 1, 1);
        tbl[14] = mk(0, 8'h40, 8'h04, 1, 8'h40, 6, 1, 0, 1);
        tbl[15] = mk(0, 8'h40, 8'h00, 1, 8'h40, 6, 0, 1, 1);
        tbl[16] = mk(0, 8'h00, 8'h00, 1, 8'h00, 6, 0, 0, 0);
        tbl[17] = mk(0, 8'h00, 8'h00, 1, 8'h00, 6, 0, 0, 0);
        tbl[18] = mk(0, 8'h10, 8'h10, 0, 8'h10, 4, 0, 0, 1);
        tbl[19] = mk(0, 8'h10, 8'h10, 1, 8'h10, 4, 1, 1, 1);
        tbl[20] = mk(0, 8'h10, 8'h10, 1, 8'h10, 4, 1, 1, 1);
        tbl[21] = mk(1, 8'h11, 8'h10, 1, 8'h00, 0, 0, 0, 0);
        tbl[22] = mk(0, 8'h11, 8'h01, 0, 8'h01, 0, 0, 0, 1);
        tbl[23] = mk(0, 8'h21, 8'h01, 1, 8'h01, 0, 1, 1, 1);
        tbl[24] = mk(0, 8'h21, 8'h01, 0, 8'h01, 0, 1, 0, 1);
        tbl[25] = mk(0, 8'h21, 8'h01, 0, 8'h01, 0, 1, 0, 1);
        tbl[26] = mk(0, 8'h21, 8'h01, 1, 8'h01, 0, 1, 1, 1);
        tbl[27] = mk(0, 8'h21, 8'h01, 1, 8'h01, 0, 1, 1, 1);
        tbl[28] = mk(0, 8'h21, 8'h01, 1, 8'h20, 5, 1, 1, 1);
        tbl[29] = mk(0, 8'h21, 8'h01, 0, 8'h20, 5, 1, 0, 1);

        rst = 1'b1; req = '0; d = '0; ready = 1'b0;
        #2;

        for (int i = 0; i < 30; i++) begin
            rst   = tbl[i].rst;
            req   = tbl[i].req;
            d     = tbl[i].d;
            ready = tbl[i].ready;
            step();
            check($sformatf("vec%0d", i), {gnt4, sel4, y4, yv4, busy4},
                  {tbl[i].gnt, tbl[i].sel, tbl[i].y, tbl[i].yv, tbl[i].busy});
        end

        // HOLD_MAX=1: strict per-beat rotation across all eight sources.
        dv = 8'hA5;
        rst = 1'b1; req = 8'hFF; d = dv; ready = 1'b1;
        step();
        check("h1_reset", {gnt1, sel1, y1, yv1, busy1}, 14'h0);
        rst = 1'b0;
        step();
        check("h1_first", {gnt1, sel1, y1, yv1, busy1}, {8'h01, 3'd0, 1'b0, 1'b0, 1'b1});
        for (int i = 1; i <= 10; i++) begin
            k = i % 8;
            step();
            check($sformatf("h1_rot%0d", i), {gnt1, sel1, y1, yv1, busy1},
                  {8'(1) << k, 3'(k), dv[(i - 1) % 8], 1'b1, 1'b1});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
